// File: rtl/alu_bist_controller_if.sv
// ALU operand/result bus between the BIST controller (master) and the ALU (slave).
interface alu_bist_controller_if #(
    parameter int unsigned WIDTH = 4
);
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             select;  // 1 = add, 0 = subtract
    logic [WIDTH-1:0] result;
    logic             zero;

    modport master (
        output a,
        output b,
        output select,
        input  result,
        input  zero
    );

    modport slave (
        input  a,
        input  b,
        input  select,
        output result,
        output zero
    );
endinterface

// File: rtl/alu_bist_controller.sv
// Built-in self-test driver for the add/subtract ALU: sweeps every {select, A, B} vector,
// compares the ALU against a reference model and reports pass, error count and first failure.
module alu_bist_controller #(
    parameter int unsigned WIDTH = 4,
    parameter int unsigned ERR_W = 10
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    alu_bist_controller_if.master alu,
    output logic                  busy,
    output logic                  done,
    output logic                  pass,
    output logic [ERR_W-1:0]      err_count,
    output logic [2*WIDTH:0]      first_fail
);
    localparam int unsigned VW = 2 * WIDTH + 1;
    localparam logic [VW-1:0]    VLast  = '1;
    localparam logic [ERR_W-1:0] ErrMax = '1;

    typedef enum logic [1:0] {StIdle, StDrive, StCheck, StDone} state_t;

    state_t           state;
    logic [VW-1:0]    v;
    logic [WIDTH-1:0] v_a;
    logic [WIDTH-1:0] v_b;
    logic             v_sel;
    logic [WIDTH-1:0] exp_out;
    logic             exp_zero;
    logic             mismatch;
    logic             launch;

    // Reference model for the vector under test and the run-launch decision.
    always_comb begin
        v_sel    = v[VW-1];
        v_a      = v[2*WIDTH-1:WIDTH];
        v_b      = v[WIDTH-1:0];
        exp_out  = v_sel ? (v_a + v_b) : (v_a - v_b);
        exp_zero = (exp_out == '0);
        mismatch = (alu.result != exp_out) || (alu.zero != exp_zero);
        // The first DONE cycle still has busy high while results are finalised, so a start
        // arriving then is ignored like any other start during the run.
        launch   = start && ((state == StIdle) || ((state == StDone) && !busy));
    end

    // Test sequencer with registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= StIdle;
            v          <= '0;
            alu.a      <= '0;
            alu.b      <= '0;
            alu.select <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            pass       <= 1'b0;
            err_count  <= '0;
            first_fail <= '0;
        end else if (launch) begin
            state      <= StDrive;
            v          <= '0;
            busy       <= 1'b1;
            done       <= 1'b0;
            pass       <= 1'b0;
            err_count  <= '0;
            first_fail <= '0;
        end else begin
            unique case (state)
                StIdle: begin
                    state <= StIdle;
                end
                StDrive: begin
                    alu.a      <= v_a;
                    alu.b      <= v_b;
                    alu.select <= v_sel;
                    state      <= StCheck;
                end
                StCheck: begin
                    if (mismatch) begin
                        if (err_count != ErrMax) begin
                            err_count <= err_count + 1'b1;
                        end
                        if (err_count == '0) begin
                            first_fail <= v;
                        end
                    end
                    if (v == VLast) begin
                        state <= StDone;
                    end else begin
                        v     <= v + 1'b1;
                        state <= StDrive;
                    end
                end
                StDone: begin
                    // Finalise once, using the count that includes the last vector.
                    if (busy) begin
                        busy <= 1'b0;
                        done <= 1'b1;
                        pass <= (err_count == '0);
                    end
                end
                default: state <= StIdle;
            endcase
        end
    end
endmodule

// File: tb/tb_alu_bist_controller.sv
// Directed bench: behavioural ALU with selectable faults driving two controllers
// (ERR_W=10 and a saturating ERR_W=4 instance on a permanently faulty ALU).
module tb_alu_bist_controller;
    logic clk = 1'b0;
    logic reset;
    logic start;
    int   mode;  // 0 healthy, 1 result[0] stuck at 0, 2 zero flag inverted

    always #5 clk = ~clk;

    alu_bist_controller_if #(.WIDTH(4)) bus ();
    alu_bist_controller_if #(.WIDTH(4)) bus2 ();

    logic       busy, done, pass;
    logic [9:0] err_count;
    logic [8:0] first_fail;
    logic       busy2, done2, pass2;
    logic [3:0] err_count2;
    logic [8:0] first_fail2;

    int n_checks = 0;
    int n_errors = 0;

    alu_bist_controller #(.WIDTH(4), .ERR_W(10)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .alu        (bus.master),
        .busy       (busy),
        .done       (done),
        .pass       (pass),
        .err_count  (err_count),
        .first_fail (first_fail)
    );

    alu_bist_controller #(.WIDTH(4), .ERR_W(4)) dut2 (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .alu        (bus2.master),
        .busy       (busy2),
        .done       (done2),
        .pass       (pass2),
        .err_count  (err_count2),
        .first_fail (first_fail2)
    );

    // Behavioural ALU for the main DUT with selectable fault.
    logic [3:0] r1;
    always_comb begin
        r1 = bus.select ? (bus.a + bus.b) : (bus.a - bus.b);
        if (mode == 1) r1[0] = 1'b0;
        bus.result = r1;
        bus.zero   = (r1 == 4'd0) ^ (mode == 2);
    end

    // Behavioural ALU for the saturation DUT: zero flag always inverted.
    logic [3:0] r2;
    always_comb begin
        r2 = bus2.select ? (bus2.a + bus2.b) : (bus2.a - bus2.b);
        bus2.result = r2;
        bus2.zero   = (r2 != 4'd0);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    // Launch a run, optionally re-pulse start mid-run, and count cycles until done.
    task automatic run(input string tag, input int mid_pulse);
        int cycles;
        pulse_start();
        check({tag, ":busy_rise"}, 32'(busy), 32'd1);
        check({tag, ":done_clr"}, 32'(done), 32'd0);
        check({tag, ":err_clr"}, 32'(err_count), 32'd0);
        check({tag, ":ff_clr"}, 32'(first_fail), 32'd0);
        check({tag, ":pass_clr"}, 32'(pass), 32'd0);
        cycles = 0;
        while (!done && cycles < 2000) begin
            if (mid_pulse > 0 && cycles == mid_pulse) start = 1'b1;
            @(posedge clk);
            #1;
            start = 1'b0;
            cycles++;
        end
        check({tag, ":cycles"}, 32'(cycles), 32'd1025);
        check({tag, ":busy_fall"}, 32'(busy), 32'd0);
    endtask

    initial begin
        reset = 1'b1;
        start = 1'b0;
        mode  = 0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_pass", 32'(pass), 32'd0);
        check("rst_err", 32'(err_count), 32'd0);
        check("rst_ff", 32'(first_fail), 32'd0);
        check("rst_a", 32'(bus.a), 32'd0);
        check("rst_b", 32'(bus.b), 32'd0);
        check("rst_sel", 32'(bus.select), 32'd0);
        reset = 1'b0;

        // Healthy ALU.
        mode = 0;
        run("t1", 0);
        check("t1_pass", 32'(pass), 32'd1);
        check("t1_err", 32'(err_count), 32'd0);
        check("t1_ff", 32'(first_fail), 32'd0);
        check("t1_hold_sel", 32'(bus.select), 32'd1);
        check("t1_hold_a", 32'(bus.a), 32'hf);
        check("t1_hold_b", 32'(bus.b), 32'hf);
        repeat (3) @(posedge clk);
        #1;
        check("t1_done_hold", 32'(done), 32'd1);
        check("t1_pass_hold", 32'(pass), 32'd1);

        // result[0] stuck at 0: half the vectors fail, first is 0-1.
        mode = 1;
        run("t2", 0);
        check("t2_err", 32'(err_count), 32'd256);
        check("t2_pass", 32'(pass), 32'd0);
        check("t2_ff", 32'(first_fail), 32'h001);

        // Zero flag inverted: every vector fails.
        mode = 2;
        run("t3", 0);
        check("t3_err", 32'(err_count), 32'd512);
        check("t3_ff", 32'(first_fail), 32'h000);
        check("t3_pass", 32'(pass), 32'd0);
        // Narrow counter saturates.
        check("t4_done", 32'(done2), 32'd1);
        check("t4_err_sat", 32'(err_count2), 32'd15);
        check("t4_ff", 32'(first_fail2), 32'h000);
        check("t4_pass", 32'(pass2), 32'd0);

        // Reset mid-run discards partial results.
        mode = 2;
        pulse_start();
        repeat (100) @(posedge clk);
        #1;
        check("t5_partial_err", 32'(err_count != 10'd0), 32'd1);
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        check("t5_busy", 32'(busy), 32'd0);
        check("t5_done", 32'(done), 32'd0);
        check("t5_err", 32'(err_count), 32'd0);
        check("t5_ff", 32'(first_fail), 32'd0);
        check("t5_a", 32'(bus.a), 32'd0);
        check("t5_b", 32'(bus.b), 32'd0);
        check("t5_sel", 32'(bus.select), 32'd0);
        mode = 0;
        run("t5r", 0);
        check("t5r_pass", 32'(pass), 32'd1);

        // start while busy is ignored; start in DONE restarts and clears results.
        mode = 2;
        run("t6", 50);
        check("t6_err", 32'(err_count), 32'd512);
        check("t6_ff", 32'(first_fail), 32'h000);
        mode = 0;
        run("t6r", 0);
        check("t6r_pass", 32'(pass), 32'd1);
        check("t6r_err", 32'(err_count), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
